// File: rtl/sd_bram_blk_reader.sv
// Block-buffer RAM reader: fetches N words from a registered-read RAM port and
// streams them out as a valid/ready byte stream, most significant byte first.
module sd_bram_blk_reader #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 66
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] num_words,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_wr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              byte_last,
    output logic              busy,
    output logic              done
);

    localparam int BYTES = DATA_W / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_CAP,
        S_SEND,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  words_left;
    logic [DATA_W-1:0]  word_q;
    logic [CNT_W-1:0]   byte_cnt;
    logic               last_byte;
    logic               hs;
    logic [ADDR_W-1:0]  addr_nxt;

    assign last_byte = (byte_cnt == CNT_W'(BYTES - 1));
    assign hs        = byte_valid & byte_ready;
    assign addr_nxt  = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start)
                    state_d = (num_words == '0) ? S_DONE : S_RD_ADDR;
            end
            S_RD_ADDR: state_d = S_RD_CAP;
            S_RD_CAP:  state_d = S_SEND;
            S_SEND: begin
                // words_left was already decremented when this word was captured
                if (hs && last_byte)
                    state_d = (words_left != '0) ? S_RD_ADDR : S_DONE;
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            words_left <= '0;
            word_q     <= '0;
            byte_cnt   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q     <= start_addr;
                        words_left <= num_words;
                    end
                end
                S_RD_CAP: begin
                    word_q     <= bram_dout;
                    byte_cnt   <= '0;
                    addr_q     <= addr_nxt;
                    words_left <= words_left - ADDR_W'(1);
                end
                S_SEND: begin
                    if (hs && !last_byte)
                        byte_cnt <= byte_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        int sel;
        sel        = DATA_W - 1 - 8 * int'(byte_cnt);
        bram_addr  = addr_q;
        bram_wr    = 1'b0;
        byte_valid = (state_q == S_SEND);
        byte_data  = byte_valid ? word_q[sel -: 8] : 8'h00;
        byte_last  = byte_valid && (words_left == '0) && last_byte;
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_sd_bram_blk_reader.sv
// Randomized scoreboard bench for sd_bram_blk_reader against a queue-based byte model.
module tb_sd_bram_blk_reader;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 66;
    localparam int BYTES  = DATA_W / 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] num_words;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_wr;
    logic [DATA_W-1:0] bram_dout;
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic              byte_last;
    logic              busy;
    logic              done;

    sd_bram_blk_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
        .num_words(num_words), .bram_addr(bram_addr), .bram_wr(bram_wr),
        .bram_dout(bram_dout), .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .byte_last(byte_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk)
        bram_dout <= (int'(bram_addr) < DEPTH) ? mem[bram_addr] : '0;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0, n_err = 0;
    int   popped = 0, done_cnt = 0, xerr = 0, wrerr = 0;
    bit   rdy_rand = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a block is simply the byte-serialisation of words sa, sa+1, ... mod DEPTH.
    task automatic push_block(input int sa, input int n);
        exp_t e;
        logic [DATA_W-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = mem[(sa + i) % DEPTH];
            for (int b = 0; b < BYTES; b++) begin
                e.d    = 8'(w >> (8 * (BYTES - 1 - b)));
                e.last = (i == n - 1) && (b == BYTES - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    initial begin
        byte_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            byte_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pops, stall stability, X and write-strobe watch.
    initial begin
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data  = '0;
        logic       prev_last  = 1'b0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if ($isunknown({byte_data, byte_valid, byte_last, busy, done, bram_addr, bram_wr}))
                    xerr++;
                if (bram_wr !== 1'b0) wrerr++;
                if (prev_stall)
                    check("stall_hold", {byte_valid, byte_last, byte_data}, {1'b1, prev_last, prev_data});
                if (byte_valid && byte_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL extra_byte: got %0h expected none", byte_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", {byte_last, byte_data}, {e.last, e.d});
                        popped++;
                    end
                end
                if (done) done_cnt++;
                prev_stall = byte_valid && !byte_ready;
                prev_data  = byte_data;
                prev_last  = byte_last;
            end
        end
    end

    task automatic issue_start(input int sa, input int n);
        @(posedge clk);
        #2;
        start      = 1'b1;
        start_addr = ADDR_W'(sa);
        num_words  = ADDR_W'(n);
        @(posedge clk);
        #2;
        start      = 1'b0;
        start_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        num_words  = ADDR_W'($urandom_range(0, DEPTH));
    endtask

    task automatic run_block(input int sa, input int n, input bit timed, input int mid_k, input int mid_addr);
        int k = 0;
        bit got = 1'b0;
        int d0;
        d0 = done_cnt;
        push_block(sa, n);
        issue_start(sa, n);
        while (k < 4000 && !got) begin
            @(negedge clk);
            k++;
            if (k == 1) check("busy_after_start", busy, 1);
            if (timed && n > 0 && k <= 3) check("first_valid_latency", byte_valid, k == 3);
            if (k == mid_k) begin
                start = 1'b1;
                start_addr = ADDR_W'(mid_addr);
                num_words = ADDR_W'(5);
            end else if (k == mid_k + 1) begin
                start = 1'b0;
            end
            if (done) got = 1'b1;
        end
        if (!got) begin
            check("done_timeout", 0, 1);
            return;
        end
        if (n == 0) check("zero_done_latency", (k >= 1 && k <= 2), 1);
        else if (timed) check("done_latency", k, n * (BYTES + 2) + 1);
        @(negedge clk);
        check("done_one_cycle", {done, busy}, 2'b00);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("done_count", done_cnt - d0, 1);
    endtask

    task automatic reset_mid(input int sa);
        int k = 0;
        int p0;
        int d0;
        p0 = popped;
        d0 = done_cnt;
        push_block(sa, 4);
        issue_start(sa, 4);
        while (k < 4000 && popped < p0 + BYTES + 3) begin
            @(negedge clk);
            k++;
        end
        if (k >= 4000) check("reset_mid_timeout", 0, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("reset_mid_outputs", {bram_addr, bram_wr, byte_data, byte_valid, byte_last, busy, done}, 0);
        check("reset_mid_no_done", done_cnt - d0, 0);
        exp_q.delete();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        num_words  = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
        mem[0] = 64'h0123_4567_89AB_CDEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {bram_addr, bram_wr, byte_data, byte_valid, byte_last, busy, done}, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Single known word, full-rate sink
        run_block(0, 1, 1'b1, 0, 0);

        // Long block with address wrap, known pattern
        for (int i = 0; i < DEPTH; i++) mem[i] = {32'(i) ^ 32'hA5A5_0000, ~32'(i)};
        run_block(10, 64, 1'b1, 0, 0);

        // Same 3-word block unstalled then under random back-pressure
        run_block(20, 3, 1'b1, 0, 0);
        rdy_rand = 1'b1;
        run_block(20, 3, 1'b0, 0, 0);
        rdy_rand = 1'b0;

        // Empty block
        run_block(5, 0, 1'b0, 0, 0);

        // Second start mid-block must be dropped
        run_block(30, 4, 1'b1, 7, 50);

        // Reset during word 2 of 4, then a fresh wrapping block
        reset_mid(40);
        run_block(64, 3, 1'b1, 0, 0);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
            rdy_rand = 1'($urandom_range(0, 1));
            run_block($urandom_range(0, DEPTH - 1), $urandom_range(0, 10), 1'b0, 0, 0);
        end
        rdy_rand = 1'b0;

        check("no_x_outputs", xerr, 0);
        check("bram_wr_zero", wrerr, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
